// File: rtl/axil_stream_bridge.sv
// AXI4-Lite slave bridging register accesses to AXI-Stream TX/RX FIFOs.
// DATA writes push TX, DATA reads pop RX; STATUS and CTRL give counts, sticky errors and flushes.
module axil_stream_bridge #(
  parameter int STREAM_W = 32,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [3:0]          s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [3:0]          s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [STREAM_W-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  input  logic [STREAM_W-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_CW = RX_AW + 1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [STREAM_W-1:0] tx_mem [TX_DEPTH];
  logic [STREAM_W-1:0] rx_mem [RX_DEPTH];
  logic [TX_AW-1:0]    tx_wr_ptr, tx_rd_ptr;
  logic [RX_AW-1:0]    rx_wr_ptr, rx_rd_ptr;
  logic [TX_CW-1:0]    tx_count;
  logic [RX_CW-1:0]    rx_count;
  logic                tx_drop, rx_underflow;

  logic [1:0] wr_sel, rd_sel;
  logic wr_fire, rd_fire, tx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_drop_set, rx_uf_set, ctrl_wr, tx_flush, rx_flush, sticky_clr;
  logic wr_err, rd_err;
  logic [31:0] rd_data, status;
  logic unused_bits;

  assign wr_sel   = s_axi_awaddr[3:2];
  assign rd_sel   = s_axi_araddr[3:2];
  assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
  assign rx_empty = (rx_count == '0);

  // Readies are qualified by aresetn so nothing is accepted while reset is held.
  assign wr_fire       = aresetn && (w_state == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
  assign rd_fire       = aresetn && (r_state == R_IDLE) && s_axi_arvalid;
  assign s_axi_awready = wr_fire;
  assign s_axi_wready  = wr_fire;
  assign s_axi_arready = aresetn && (r_state == R_IDLE);
  assign s_axis_tready = aresetn && (rx_count != RX_CW'(RX_DEPTH));
  assign m_axis_tvalid = (tx_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? tx_mem[tx_rd_ptr] : '0;

  assign tx_push     = wr_fire && (wr_sel == 2'd0) && !tx_full;
  assign tx_drop_set = wr_fire && (wr_sel == 2'd0) && tx_full;
  assign tx_pop      = m_axis_tvalid && m_axis_tready;
  assign rx_push     = s_axis_tvalid && s_axis_tready;
  assign rx_pop      = rd_fire && (rd_sel == 2'd0) && !rx_empty;
  assign rx_uf_set   = rd_fire && (rd_sel == 2'd0) && rx_empty;
  assign ctrl_wr     = wr_fire && (wr_sel == 2'd2) && s_axi_wstrb[0];
  assign tx_flush    = ctrl_wr && s_axi_wdata[0];
  assign rx_flush    = ctrl_wr && s_axi_wdata[1];
  assign sticky_clr  = ctrl_wr && s_axi_wdata[2];
  assign wr_err      = tx_drop_set || (wr_sel == 2'd3);

  assign status = {14'd0, rx_underflow, tx_drop, 8'(tx_count), 8'(rx_count)};
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb[3:1], s_axi_wdata};

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_sel)
      2'd0: begin
        rd_err = rx_empty;
        if (!rx_empty) rd_data = 32'(rx_mem[rx_rd_ptr]);
      end
      2'd1: rd_data = status;
      2'd2: rd_data = '0;
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state     <= W_IDLE;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (wr_fire) begin
          w_state      <= W_RESP;
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= wr_err ? SLVERR : OKAY;
        end
        W_RESP: if (s_axi_bready) begin
          w_state      <= W_IDLE;
          s_axi_bvalid <= 1'b0;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= R_IDLE;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= OKAY;
      s_axi_rdata  <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (rd_fire) begin
          r_state      <= R_RESP;
          s_axi_rvalid <= 1'b1;
          s_axi_rresp  <= rd_err ? SLVERR : OKAY;
          s_axi_rdata  <= rd_data;
        end
        R_RESP: if (s_axi_rready) begin
          r_state      <= R_IDLE;
          s_axi_rvalid <= 1'b0;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= s_axi_wdata[STREAM_W-1:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= s_axis_tdata;
  end

  // Flush outranks any push/pop landing in the same cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn || tx_flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + TX_CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - TX_CW'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || rx_flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + RX_CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - RX_CW'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tx_drop      <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (tx_drop_set)     tx_drop <= 1'b1;
      else if (sticky_clr) tx_drop <= 1'b0;
      if (rx_uf_set)       rx_underflow <= 1'b1;
      else if (sticky_clr) rx_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_stream_bridge.sv
// Directed bench for axil_stream_bridge: register map, FIFO limits, back-pressure and reset.
module tb_axil_stream_bridge;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;

  int total = 0;
  int bad = 0;

  always #5 aclk = ~aclk;

  axil_stream_bridge #(.STREAM_W(32), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    @(negedge aclk);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    #1;
    n = 0;
    while (!s_axi_awready && n < 20) begin @(negedge aclk); #1; n++; end
    if (n == 20) check("aw_timeout", 32'd1, 32'd0);
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (n == 20) check("b_timeout", 32'd1, 32'd0);
    resp = s_axi_bresp;
    $display("wr addr=0x%0h data=0x%08h strb=0x%0h resp=%0d", a, d, s, resp);
    @(posedge aclk); #1;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge aclk);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    #1;
    n = 0;
    while (!s_axi_arready && n < 20) begin @(negedge aclk); #1; n++; end
    if (n == 20) check("ar_timeout", 32'd1, 32'd0);
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (n == 20) check("r_timeout", 32'd1, 32'd0);
    d = s_axi_rdata; resp = s_axi_rresp;
    $display("rd addr=0x%0h data=0x%08h resp=%0d", a, d, resp);
    @(posedge aclk); #1;
  endtask

  task automatic axis_push(input logic [31:0] d);
    @(negedge aclk);
    s_axis_tdata = d; s_axis_tvalid = 1'b1;
    #1;
    check("axis_push_ready", 32'(s_axis_tready), 32'd1);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    $display("axis push data=0x%08h", d);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [31:0] words [4];
    words[0] = 32'h1111_0001; words[1] = 32'h2222_0002;
    words[2] = 32'h3333_0003; words[3] = 32'h4444_0004;

    aresetn = 1'b0;
    s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    s_axi_araddr = '0; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    m_axis_tready = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;

    // Reset: readies forced low even with valids asserted.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_wready", 32'(s_axi_wready), 32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd0);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_bresp", 32'(s_axi_bresp), 32'd0);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_arready", 32'(s_axi_arready), 32'd1);
    check("post_rst_s_tready", 32'(s_axis_tready), 32'd1);

    // Three TX writes with sink stalled, then drain in order.
    axi_write(4'h0, 32'hA5A5_0001, 4'hF, resp); check("tx1_resp", 32'(resp), 32'd0);
    check("tx1_visible", 32'(m_axis_tvalid), 32'd1);
    axi_write(4'h0, 32'h0000_0002, 4'hF, resp); check("tx2_resp", 32'(resp), 32'd0);
    axi_write(4'h0, 32'h0000_0003, 4'hF, resp); check("tx3_resp", 32'(resp), 32'd0);
    axi_read(4'h4, rd, resp); check("status_tx3", rd, 32'h0000_0300);
    check("status_tx3_resp", 32'(resp), 32'd0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("tdata_held", m_axis_tdata, 32'hA5A5_0001);
    m_axis_tready = 1'b1;
    @(negedge aclk); check("drain_2", m_axis_tdata, 32'h0000_0002);
    @(negedge aclk); check("drain_3", m_axis_tdata, 32'h0000_0003);
    @(negedge aclk); check("drain_empty", 32'(m_axis_tvalid), 32'd0);
    m_axis_tready = 1'b0;

    // Overfill TX: fifth write dropped.
    for (int i = 0; i < 5; i++) begin
      axi_write(4'h0, 32'h0000_0010 + 32'(i), 4'hF, resp);
      check($sformatf("fill%0d_resp", i), 32'(resp), (i == 4) ? 32'd2 : 32'd0);
    end
    axi_read(4'h4, rd, resp); check("status_drop", rd, 32'h0001_0400);
    axi_write(4'h8, 32'h0000_0004, 4'hF, resp); check("ctrl_clr_resp", 32'(resp), 32'd0);
    axi_read(4'h4, rd, resp); check("status_clr", rd, 32'h0000_0400);
    axi_write(4'h8, 32'h0000_0001, 4'h0, resp);
    axi_read(4'h4, rd, resp); check("status_nostrb", rd, 32'h0000_0400);
    axi_write(4'h8, 32'h0000_0001, 4'h1, resp);
    axi_read(4'h4, rd, resp); check("status_flush", rd, 32'h0000_0000);
    axi_read(4'h8, rd, resp); check("ctrl_rd_data", rd, 32'd0);
    check("ctrl_rd_resp", 32'(resp), 32'd0);
    axi_read(4'hC, rd, resp); check("unmapped_rd_resp", 32'(resp), 32'd2);
    check("unmapped_rd_data", rd, 32'd0);
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, resp); check("unmapped_wr_resp", 32'(resp), 32'd2);
    axi_read(4'h4, rd, resp); check("unmapped_wr_noeffect", rd, 32'h0000_0000);

    // Fill RX, read back in order, then underflow.
    for (int i = 0; i < 4; i++) axis_push(words[i]);
    @(negedge aclk); check("rx_full_tready", 32'(s_axis_tready), 32'd0);
    axi_read(4'h4, rd, resp); check("status_rx4", rd, 32'h0000_0004);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'h0, rd, resp);
      check($sformatf("rx%0d_data", i), rd, words[i]);
      check($sformatf("rx%0d_resp", i), 32'(resp), 32'd0);
    end
    axi_read(4'h0, rd, resp); check("uf_data", rd, 32'd0); check("uf_resp", 32'(resp), 32'd2);
    axi_read(4'h4, rd, resp); check("status_uf", rd, 32'h0002_0000);
    axi_write(4'h8, 32'h0000_0004, 4'h1, resp);

    // Simultaneous RX push and DATA read at rx_count=2.
    axis_push(32'hB000_0000); axis_push(32'hB000_0001);
    @(negedge aclk);
    s_axi_araddr = 4'h0; s_axi_arvalid = 1'b1;
    s_axis_tdata = 32'hB000_0002; s_axis_tvalid = 1'b1;
    #1; check("sim_arready", 32'(s_axi_arready), 32'd1);
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0; s_axis_tvalid = 1'b0;
    check("sim_rvalid", 32'(s_axi_rvalid), 32'd1);
    check("sim_rdata", s_axi_rdata, 32'hB000_0000);
    @(posedge aclk); #1;
    axi_read(4'h4, rd, resp); check("sim_status", rd, 32'h0000_0002);
    axi_read(4'h0, rd, resp); check("sim_next1", rd, 32'hB000_0001);
    axi_read(4'h0, rd, resp); check("sim_next2", rd, 32'hB000_0002);

    // R back-pressure: response held, no new AR accepted.
    axis_push(32'hC0DE_0001);
    s_axi_rready = 1'b0;
    @(negedge aclk); s_axi_araddr = 4'h0; s_axi_arvalid = 1'b1;
    @(posedge aclk); #1; s_axi_araddr = 4'h4;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check($sformatf("rhold%0d_rvalid", i), 32'(s_axi_rvalid), 32'd1);
      check($sformatf("rhold%0d_rdata", i), s_axi_rdata, 32'hC0DE_0001);
      check($sformatf("rhold%0d_arready", i), 32'(s_axi_arready), 32'd0);
    end
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    check("r_release", 32'(s_axi_rvalid), 32'd0);

    // B back-pressure on the third write, then reset mid-response.
    axi_write(4'h0, 32'hD000_0001, 4'hF, resp);
    axi_write(4'h0, 32'hD000_0002, 4'hF, resp);
    axis_push(32'hE000_0001);
    s_axi_bready = 1'b0;
    @(negedge aclk); s_axi_awaddr = 4'h0; s_axi_wdata = 32'hD000_0003;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(posedge aclk); #1; s_axi_wdata = 32'hD000_0004;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check($sformatf("bhold%0d_bvalid", i), 32'(s_axi_bvalid), 32'd1);
      check($sformatf("bhold%0d_bresp", i), 32'(s_axi_bresp), 32'd0);
      check($sformatf("bhold%0d_awready", i), 32'(s_axi_awready), 32'd0);
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check("midrst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("midrst_s_tready", 32'(s_axis_tready), 32'd0);
    @(negedge aclk); aresetn = 1'b1; s_axi_bready = 1'b1;
    axi_read(4'h4, rd, resp); check("midrst_status", rd, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
